msx_joy_port_router: RTL and testbench

// - Routes joystick and mouse sources onto N_PORTS MSX general-purpose ports, driving the emsx_top pJoyA/pJoyB-style inputs.
// - Per port it merges the HPS joystick with a synchronised, debounced DB9 joystick, applies the port-0/1 swap, and auto-selects the mouse.
// - Generalises the fixed two-port joy/DB9/mouse glue to parametrised port count, DB9 count and debounce.

---
 rtl/msx_joy_port_router.sv | 216 +++++++++++++++++++++
 tb/tb_msx_joy_port_router.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_joy_port_router.sv
// msx_joy_port_router: merges HPS and debounced DB9 joysticks onto N_PORTS MSX ports, with port 0/1 swap
// and mouse auto-selection. Optional autofire on joy_hps bit 6 is built when JOY_AUTOFIRE_EN is defined.
module msx_joy_port_router #(
  parameter int N_PORTS      = 2,
  parameter int DB9_PORTS    = 1,
  parameter int DEBOUNCE_CYC = 65536,
  parameter int AUTOFIRE_DIV = 1000000
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [16*N_PORTS-1:0]    joy_hps,
  input  logic [6*DB9_PORTS-1:0]   joy_db9,
  input  logic                     swap,
  input  logic [$clog2(N_PORTS):0] mouse_port,
  input  logic                     mouse_stb,
  input  logic [5:0]               mouse_data,
  input  logic [N_PORTS-1:0]       mouse_strobe,
  output logic                     msx_strobe,
  output logic [6*N_PORTS-1:0]     msx_joy,
  output logic [N_PORTS-1:0]       mouse_active
);

  localparam int MP_W  = $clog2(N_PORTS) + 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [0:0] ST_JOY   = 1'b0;
  localparam logic [0:0] ST_MOUSE = 1'b1;

  logic [6*DB9_PORTS-1:0] db9_acc;
  logic [6*N_PORTS-1:0]   db9_pad;
  logic [5:0]             logical  [N_PORTS];
  logic [5:0]             physical [N_PORTS];

  // DB9 inputs: two-flop synchroniser, then accept a value only after it has been
  // seen unchanged (and different from the accepted one) for DEBOUNCE_CYC samples.
  for (genvar gi = 0; gi < DB9_PORTS; gi++) begin : g_db9
    logic [5:0]       meta_q, meta_d;
    logic [5:0]       sync_q, sync_d;
    logic [5:0]       prev_q, prev_d;
    logic [5:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      meta_d = joy_db9[6*gi +: 6];
      sync_d = meta_q;
      prev_d = sync_q;
      acc_d  = acc_q;
      cnt_d  = '0;
      if (sync_q != acc_q) begin
        // a new candidate value restarts the stability window at one sample
        if (sync_q != prev_q) begin
          cnt_d = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CNT_W'(DEBOUNCE_CYC)) begin
          acc_d = sync_q;
          cnt_d = '0;
        end
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        meta_q <= '0;
        sync_q <= '0;
        prev_q <= '0;
        acc_q  <= '0;
        cnt_q  <= '0;
      end else begin
        meta_q <= meta_d;
        sync_q <= sync_d;
        prev_q <= prev_d;
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
      end
    end

    assign db9_acc[6*gi +: 6] = acc_q;
  end

  assign db9_pad = (6*N_PORTS)'(db9_acc);

`ifdef JOY_AUTOFIRE_EN
  localparam int AF_W = $clog2(AUTOFIRE_DIV + 1);

  logic [AF_W-1:0] af_cnt_q, af_cnt_d;
  logic            af_phase_q, af_phase_d;

  always_comb begin
    af_cnt_d   = af_cnt_q + 1'b1;
    af_phase_d = af_phase_q;
    if (af_cnt_q == AF_W'(AUTOFIRE_DIV - 1)) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end
`endif

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      logical[p] = joy_hps[16*p +: 6] | db9_pad[6*p +: 6];
`ifdef JOY_AUTOFIRE_EN
      logical[p][4] = logical[p][4] | (joy_hps[16*p+6] & af_phase_q);
`endif
    end
  end

  if (N_PORTS >= 2) begin : g_swap
    always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
        physical[p] = logical[p];
      end
      if (swap) begin
        physical[0] = logical[1];
        physical[1] = logical[0];
      end
    end
  end else begin : g_no_swap
    logic unused_swap;
    assign physical[0] = logical[0];
    assign unused_swap = swap;
  end

  // Mouse ownership of the selected port
  logic [0:0]      state_q, state_d;
  logic            stb_prev_q, stb_prev_d;
  logic [MP_W-1:0] port_prev_q, port_prev_d;
  logic            mp_valid;
  logic            stb_edge;
  logic [5:0]      sel_phys;

  always_comb begin
    mp_valid    = (mouse_port < MP_W'(N_PORTS));
    stb_edge    = (mouse_stb != stb_prev_q);
    stb_prev_d  = mouse_stb;
    port_prev_d = mouse_port;
    sel_phys    = '0;
    msx_strobe  = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (mouse_port == MP_W'(p)) begin
        sel_phys   = physical[p];
        msx_strobe = mouse_strobe[p];
      end
    end

    state_d = state_q;
    if (!mp_valid || (mouse_port != port_prev_q)) begin
      state_d = ST_JOY;
    end else if (state_q == ST_JOY) begin
      // joystick activity on the port vetoes a simultaneous mouse packet
      if (stb_edge && (sel_phys == 6'd0)) begin
        state_d = ST_MOUSE;
      end
    end else if (sel_phys != 6'd0) begin
      state_d = ST_JOY;
    end
  end

  // Output pins are active-low, ordered {F2,F1,R,L,D,U}
  logic [6*N_PORTS-1:0] msx_joy_q, msx_joy_d;
  logic [N_PORTS-1:0]   mouse_active_q, mouse_active_d;

  always_comb begin
    msx_joy_d      = '1;
    mouse_active_d = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if ((state_d == ST_MOUSE) && (mouse_port == MP_W'(p))) begin
        msx_joy_d[6*p +: 6] = mouse_data;
        mouse_active_d[p]   = 1'b1;
      end else begin
        msx_joy_d[6*p +: 6] = ~{physical[p][5], physical[p][4], physical[p][0],
                                physical[p][1], physical[p][2], physical[p][3]};
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= ST_JOY;
      stb_prev_q     <= 1'b0;
      port_prev_q    <= '0;
      msx_joy_q      <= '1;
      mouse_active_q <= '0;
    end else begin
      state_q        <= state_d;
      stb_prev_q     <= stb_prev_d;
      port_prev_q    <= port_prev_d;
      msx_joy_q      <= msx_joy_d;
      mouse_active_q <= mouse_active_d;
    end
  end

  assign msx_joy      = msx_joy_q;
  assign mouse_active = mouse_active_q;

  logic [10*N_PORTS-1:0] hps_spare;
  logic                  unused_ok;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_spare
    assign hps_spare[10*gi +: 10] = joy_hps[16*gi+6 +: 10];
  end

  assign unused_ok = ^{hps_spare, (AUTOFIRE_DIV > 0)};

endmodule

// File: tb/tb_msx_joy_port_router.sv
// Randomised self-checking bench for msx_joy_port_router against a behavioural pin/ownership model.
// Define JOY_AUTOFIRE_EN for both bench and RTL to exercise the autofire build.
module tb_msx_joy_port_router;
  localparam int NP  = 2;
  localparam int ND  = 1;
  localparam int DEB = 8;
  localparam int AFD = 4;
  localparam int LAT = 2 + DEB + 1;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [16*NP-1:0]  joy_hps;
  logic [6*ND-1:0]   joy_db9;
  logic              swap;
  logic [1:0]        mouse_port;
  logic              mouse_stb;
  logic [5:0]        mouse_data;
  logic [NP-1:0]     mouse_strobe;
  logic              msx_strobe;
  logic [6*NP-1:0]   msx_joy;
  logic [NP-1:0]     mouse_active;

  int checks = 0;
  int errors = 0;
  logic [5:0] db9_acc_m = 6'd0;

  always #5 clk_sys = ~clk_sys;

  msx_joy_port_router #(
    .N_PORTS(NP), .DB9_PORTS(ND), .DEBOUNCE_CYC(DEB), .AUTOFIRE_DIV(AFD)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .joy_hps(joy_hps), .joy_db9(joy_db9),
    .swap(swap), .mouse_port(mouse_port), .mouse_stb(mouse_stb),
    .mouse_data(mouse_data), .mouse_strobe(mouse_strobe), .msx_strobe(msx_strobe),
    .msx_joy(msx_joy), .mouse_active(mouse_active)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Active-low MSX pins {F2,F1,R,L,D,U} from joystick bits R,L,D,U,F1,F2 (0..5)
  function automatic logic [5:0] pins(input logic [5:0] j);
    int src [6];
    logic [5:0] o;
    src = '{3, 2, 1, 0, 4, 5};
    for (int i = 0; i < 6; i++) o[i] = ~j[src[i]];
    return o;
  endfunction

  function automatic logic [5:0] phys_m(input int p);
    int src;
    logic [5:0] v;
    src = p;
    if (swap && p < 2) src = 1 - p;
    v = joy_hps[16*src +: 6];
    if (src < ND) v = v | db9_acc_m;
    return v;
  endfunction

  function automatic logic [11:0] joy_out_m();
    return {pins(phys_m(1)), pins(phys_m(0))};
  endfunction

  task automatic test_reset();
    reset = 1'b1; joy_db9 = '0; swap = 1'b0; mouse_port = 2'd0; mouse_stb = 1'b0;
    mouse_data = 6'h00; mouse_strobe = '0; joy_hps = $urandom;
    repeat (3) step();
    checks++;
    if (msx_joy !== 12'hFFF) begin errors++; $display("FAIL reset_hold msx_joy got %h exp fff", msx_joy); end
    joy_hps = '0;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (msx_joy !== 12'hFFF) begin errors++; $display("FAIL reset_joy got %h exp fff", msx_joy); end
    checks++;
    if (mouse_active !== 2'b00) begin errors++; $display("FAIL reset_active got %b exp 00", mouse_active); end
    checks++;
    if (msx_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", msx_strobe); end
    $display("txn reset msx_joy=%h active=%b", msx_joy, mouse_active);
  endtask

  task automatic test_hps_basic();
    joy_hps = '0; joy_hps[15:0] = 16'h0011;
    step();
    checks++;
    if (msx_joy !== {6'h3F, 6'b100111}) begin errors++; $display("FAIL hps_basic got %h exp %h", msx_joy, {6'h3F, 6'b100111}); end
    swap = 1'b1;
    step();
    checks++;
    if (msx_joy !== {6'b100111, 6'h3F}) begin errors++; $display("FAIL hps_swap got %h exp %h", msx_joy, {6'b100111, 6'h3F}); end
    $display("txn hps_basic swap=%b msx_joy=%h", swap, msx_joy);
    swap = 1'b0; joy_hps = '0;
    step();
  endtask

  task automatic test_random_merge();
    int mp;
    logic exp_s;
    logic [11:0] exp_j;
    for (int i = 0; i < 40; i++) begin
      joy_hps = $urandom;
`ifdef JOY_AUTOFIRE_EN
      joy_hps[6] = 1'b0; joy_hps[22] = 1'b0;
`endif
      swap = 1'($urandom_range(0, 1));
      mouse_strobe = 2'($urandom_range(0, 3));
      mouse_port = 2'($urandom_range(0, 3));
      mp = int'(mouse_port);
      #1;
      exp_s = (mp < NP) ? mouse_strobe[mp] : 1'b0;
      checks++;
      if (msx_strobe !== exp_s) begin errors++; $display("FAIL merge_strobe[%0d] got %b exp %b", i, msx_strobe, exp_s); end
      exp_j = joy_out_m();
      step();
      checks++;
      if (msx_joy !== exp_j || mouse_active !== 2'b00) begin
        errors++; $display("FAIL merge[%0d] got %h/%b exp %h/00", i, msx_joy, mouse_active, exp_j);
      end
      $display("txn merge %0d hps=%h swap=%b port=%0d msx_joy=%h", i, joy_hps, swap, mp, msx_joy);
    end
    joy_hps = '0; swap = 1'b0; mouse_port = 2'd0;
    step(); step();
  endtask

  task automatic test_db9();
    int lens [2];
    logic [5:0] v, hps0;
    lens = '{5, 7};
    for (int g = 0; g < 2; g++) begin
      joy_db9 = 6'h01;
      for (int k = 0; k < lens[g] + 12; k++) begin
        if (k == lens[g]) joy_db9 = 6'h00;
        step();
        checks++;
        if (msx_joy[5:0] !== 6'h3F) begin errors++; $display("FAIL db9_glitch%0d step %0d got %h exp 3f", lens[g], k, msx_joy[5:0]); end
      end
      $display("txn db9_glitch len=%0d msx_joy0=%h", lens[g], msx_joy[5:0]);
    end
    joy_db9 = 6'h01;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      checks++;
      if (msx_joy[5:0] !== ((k >= LAT) ? pins(6'h01) : 6'h3F)) begin
        errors++; $display("FAIL db9_hold step %0d got %h exp %h", k, msx_joy[5:0], (k >= LAT) ? pins(6'h01) : 6'h3F);
      end
    end
    db9_acc_m = 6'h01;
    swap = 1'b1;
    step();
    checks++;
    if (msx_joy !== joy_out_m()) begin errors++; $display("FAIL db9_swap got %h exp %h", msx_joy, joy_out_m()); end
    $display("txn db9_hold swap=%b msx_joy=%h", swap, msx_joy);
    swap = 1'b0;
    for (int it = 0; it < 4; it++) begin
      do v = 6'($urandom_range(1, 63)); while (v == db9_acc_m);
      hps0 = 6'($urandom_range(0, 63));
      joy_db9 = v; joy_hps[5:0] = hps0;
      repeat (LAT - 1) step();
      checks++;
      if (msx_joy[5:0] !== pins(hps0 | db9_acc_m)) begin errors++; $display("FAIL db9_early[%0d] got %h exp %h", it, msx_joy[5:0], pins(hps0 | db9_acc_m)); end
      step();
      db9_acc_m = v;
      checks++;
      if (msx_joy[5:0] !== pins(hps0 | v)) begin errors++; $display("FAIL db9_accept[%0d] got %h exp %h", it, msx_joy[5:0], pins(hps0 | v)); end
      $display("txn db9_rand %0d db9=%h hps=%h msx_joy0=%h", it, v, hps0, msx_joy[5:0]);
    end
    joy_hps = '0; joy_db9 = 6'h00;
    repeat (LAT + 1) step();
    db9_acc_m = 6'h00;
    joy_db9 = 6'h01;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      checks++;
      if (msx_joy[5:0] !== ((k >= LAT) ? pins(6'h01) : 6'h3F)) begin
        errors++; $display("FAIL db9_reset_mid step %0d got %h exp %h", k, msx_joy[5:0], (k >= LAT) ? pins(6'h01) : 6'h3F);
      end
    end
    $display("txn db9_reset_mid msx_joy0=%h", msx_joy[5:0]);
    joy_db9 = 6'h00;
    repeat (LAT + 1) step();
  endtask

  task automatic test_mouse();
    joy_hps = '0; swap = 1'b0; mouse_port = 2'd1; mouse_data = 6'h2A; mouse_strobe = 2'b10;
    step(); step();
    mouse_stb = ~mouse_stb;
    step();
    checks++;
    if (mouse_active !== 2'b10 || msx_joy !== {6'h2A, 6'h3F}) begin errors++; $display("FAIL mouse_enter got %b/%h exp 10/%h", mouse_active, msx_joy, {6'h2A, 6'h3F}); end
    checks++;
    if (msx_strobe !== 1'b1) begin errors++; $display("FAIL mouse_strobe1 got %b exp 1", msx_strobe); end
    mouse_strobe = 2'b01;
    #1;
    checks++;
    if (msx_strobe !== 1'b0) begin errors++; $display("FAIL mouse_strobe0 got %b exp 0", msx_strobe); end
    mouse_data = 6'h15;
    step();
    checks++;
    if (mouse_active !== 2'b10 || msx_joy[11:6] !== 6'h15) begin errors++; $display("FAIL mouse_data got %b/%h exp 10/15", mouse_active, msx_joy[11:6]); end
    joy_hps[16] = 1'b1;
    step();
    checks++;
    if (mouse_active !== 2'b00 || msx_joy[11:6] !== 6'b110111) begin errors++; $display("FAIL mouse_exit got %b/%h exp 00/37", mouse_active, msx_joy[11:6]); end
    $display("txn mouse_exit active=%b msx_joy=%h", mouse_active, msx_joy);
    joy_hps = '0;
    step();
    checks++;
    if (mouse_active !== 2'b00 || msx_joy !== 12'hFFF) begin errors++; $display("FAIL mouse_idle got %b/%h exp 00/fff", mouse_active, msx_joy); end
    joy_hps[18] = 1'b1; mouse_stb = ~mouse_stb;
    step();
    checks++;
    if (mouse_active !== 2'b00 || msx_joy[11:6] !== pins(6'h04)) begin errors++; $display("FAIL mouse_simul got %b/%h exp 00/%h", mouse_active, msx_joy[11:6], pins(6'h04)); end
    joy_hps = '0;
    step();
    checks++;
    if (mouse_active !== 2'b00) begin errors++; $display("FAIL mouse_simul_after got %b exp 00", mouse_active); end
    mouse_stb = ~mouse_stb;
    step();
    checks++;
    if (mouse_active !== 2'b10) begin errors++; $display("FAIL mouse_reenter got %b exp 10", mouse_active); end
    mouse_port = 2'd0;
    step();
    checks++;
    if (mouse_active !== 2'b00 || msx_joy !== 12'hFFF) begin errors++; $display("FAIL mouse_portchg got %b/%h exp 00/fff", mouse_active, msx_joy); end
    $display("txn mouse_portchg active=%b", mouse_active);
    mouse_port = 2'd2; mouse_strobe = 2'b11;
    step();
    mouse_stb = ~mouse_stb;
    step();
    checks++;
    if (mouse_active !== 2'b00 || msx_strobe !== 1'b0) begin errors++; $display("FAIL mouse_invalid got %b/%b exp 00/0", mouse_active, msx_strobe); end
    mouse_port = 2'd1;
    step();
    mouse_stb = ~mouse_stb;
    step();
    checks++;
    if (mouse_active !== 2'b10) begin errors++; $display("FAIL mouse_pre_reset got %b exp 10", mouse_active); end
    reset = 1'b1; mouse_stb = 1'b0;
    step();
    checks++;
    if (mouse_active !== 2'b00 || msx_joy !== 12'hFFF) begin errors++; $display("FAIL mouse_reset got %b/%h exp 00/fff", mouse_active, msx_joy); end
    reset = 1'b0;
    step();
    checks++;
    if (mouse_active !== 2'b00 || msx_joy !== 12'hFFF) begin errors++; $display("FAIL mouse_post_reset got %b/%h exp 00/fff", mouse_active, msx_joy); end
    $display("txn mouse_reset active=%b msx_joy=%h", mouse_active, msx_joy);
  endtask

  task automatic test_random_mouse();
    logic owner, prev_stb, exp_s;
    int prev_mp, mp, bitpos;
    logic [11:0] exp_j;
    logic [1:0] exp_a;
    joy_hps = '0; swap = 1'b0; mouse_port = 2'd1;
    step(); step();
    owner = 1'b0; prev_mp = 1; prev_stb = mouse_stb;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 4) mouse_stb = ~mouse_stb;
      joy_hps = '0;
      if ($urandom_range(0, 3) == 0) begin
        bitpos = 16 * $urandom_range(0, 1) + $urandom_range(0, 5);
        joy_hps[bitpos] = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) mouse_port = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 14) == 0) swap = ~swap;
      mouse_data = 6'($urandom);
      mouse_strobe = 2'($urandom_range(0, 3));
      mp = int'(mouse_port);
      if (mp >= NP || mp != prev_mp) owner = 1'b0;
      else if (!owner) owner = (mouse_stb != prev_stb) && (phys_m(mp) == 6'd0);
      else owner = (phys_m(mp) == 6'd0);
      prev_mp = mp; prev_stb = mouse_stb;
      exp_j = joy_out_m();
      exp_a = 2'b00;
      if (owner) begin
        exp_j[6*mp +: 6] = mouse_data;
        exp_a[mp] = 1'b1;
      end
      #1;
      exp_s = (mp < NP) ? mouse_strobe[mp] : 1'b0;
      checks++;
      if (msx_strobe !== exp_s) begin errors++; $display("FAIL rmouse_strobe[%0d] got %b exp %b", i, msx_strobe, exp_s); end
      step();
      checks++;
      if (msx_joy !== exp_j || mouse_active !== exp_a) begin
        errors++; $display("FAIL rmouse[%0d] got %h/%b exp %h/%b", i, msx_joy, mouse_active, exp_j, exp_a);
      end
      $display("txn rmouse %0d port=%0d stb=%b hps=%h swap=%b msx_joy=%h active=%b", i, mp, mouse_stb, joy_hps, swap, msx_joy, mouse_active);
    end
    joy_hps = '0; swap = 1'b0;
  endtask

  task automatic test_autofire();
    logic [5:0] exp_j;
    int ph;
    reset = 1'b1; mouse_stb = 1'b0; mouse_port = 2'd0; joy_hps = '0; swap = 1'b0;
    step(); step();
    joy_hps[6] = 1'b1;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef JOY_AUTOFIRE_EN
      ph = ((k - 1) / AFD) % 2;
`else
      ph = 0;
`endif
      exp_j = pins((ph != 0) ? 6'h10 : 6'h00);
      checks++;
      if (msx_joy[5:0] !== exp_j) begin errors++; $display("FAIL autofire step %0d got %h exp %h", k, msx_joy[5:0], exp_j); end
    end
    $display("txn autofire msx_joy0=%h", msx_joy[5:0]);
    joy_hps = '0;
  endtask

  initial begin
    test_reset();
    test_hps_basic();
    test_random_merge();
    test_db9();
    test_mouse();
    test_random_mouse();
    test_autofire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
